// File: rtl/led_pkg.sv
// Shared definitions for the LED chaser: mode encodings, FSM states and
// prescaler sizing helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_FILL   = 2'd1,
        MODE_ALT    = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bounce direction encoding
    localparam logic BDIR_UP   = 1'b0;
    localparam logic BDIR_DOWN = 1'b1;

    // Prescaler width: clog2(div), never below one bit
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// Step prescaler: counts 0..DIV-1 while run is high, holds while run is low,
// and flags the cycle in which the count sits at DIV-1 with run high.
module led_tick_div
    import led_pkg::*;
#(
    parameter int unsigned DIV = 2500000
) (
    input  logic clk,
    input  logic res,
    input  logic run,
    input  logic clear,
    output logic wrap
);

    localparam int unsigned   CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Wrap is suppressed while the chaser is reloading
    assign wrap = run && !clear && (count == LAST);

    // Prescaler counter; clear forces it back to zero during INIT
    always_ff @(posedge clk) begin
        if (res || clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/led_chaser.sv
// LED pattern chaser: SHIFT / FILL / ALT / BOUNCE patterns stepped by a
// prescaler. Define LED_CHASER_BOUNCE_EN to build the real BOUNCE pattern;
// without it mode 3 is an alias of SHIFT.
module led_chaser
    import led_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 2500000
) (
    input  logic             clk,
    input  logic             res,
    input  logic [1:0]       mode,
    input  logic             run,
    input  logic             dir,
    output logic [WIDTH-1:0] out,
    output logic             tick
);

    localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0]   ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ALT_REP  = {WIDTH{2'b01}};
    localparam logic [WIDTH-1:0]   ALT_INIT = ALT_REP[WIDTH-1:0];

    state_t           state;
    mode_t            mode_q;
    mode_t            mode_in;
    logic             clear_c;
    logic             wrap;
    logic [WIDTH-1:0] rot_c;
    logic [WIDTH-1:0] start_c;
    logic [WIDTH-1:0] step_c;
`ifdef LED_CHASER_BOUNCE_EN
    logic             bdir_q;
    logic             bdir_nxt_c;
`endif

    assign mode_in = mode_t'(mode);
    assign clear_c = (state == ST_INIT);

    led_tick_div #(
        .DIV (DIV)
    ) u_div (
        .clk   (clk),
        .res   (res),
        .run   (run),
        .clear (clear_c),
        .wrap  (wrap)
    );

    // Start pattern for the mode sampled in INIT
    always_comb begin
        start_c = dir ? MSB_ONLY : ONE;
        case (mode_in)
            MODE_FILL:   start_c = '0;
            MODE_ALT:    start_c = ALT_INIT;
`ifdef LED_CHASER_BOUNCE_EN
            MODE_BOUNCE: start_c = ONE;
`endif
            default:     start_c = dir ? MSB_ONLY : ONE;
        endcase
    end

    // Next pattern value for the registered mode
    always_comb begin
        rot_c  = dir ? {out[0], out[WIDTH-1:1]} : {out[WIDTH-2:0], out[WIDTH-1]};
        step_c = rot_c;
`ifdef LED_CHASER_BOUNCE_EN
        bdir_nxt_c = bdir_q;
`endif
        case (mode_q)
            MODE_FILL: begin
                if (out == ONES) begin
                    step_c = '0;
                end else begin
                    step_c = dir ? ((out >> 1) | MSB_ONLY) : ((out << 1) | ONE);
                end
            end
            MODE_ALT: step_c = ~out;
`ifdef LED_CHASER_BOUNCE_EN
            MODE_BOUNCE: begin
                if (bdir_q == BDIR_UP) begin
                    step_c     = out << 1;
                    bdir_nxt_c = step_c[WIDTH-1] ? BDIR_DOWN : BDIR_UP;
                end else begin
                    step_c     = out >> 1;
                    bdir_nxt_c = step_c[0] ? BDIR_UP : BDIR_DOWN;
                end
            end
`endif
            default: step_c = rot_c;
        endcase
    end

    // INIT/RUN control with registered pattern and tick
    always_ff @(posedge clk) begin
        if (res) begin
            state  <= ST_INIT;
            mode_q <= MODE_SHIFT;
            out    <= ONES;
            tick   <= 1'b0;
`ifdef LED_CHASER_BOUNCE_EN
            bdir_q <= BDIR_UP;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    mode_q <= mode_in;
                    out    <= start_c;
                    tick   <= 1'b0;
                    state  <= ST_RUN;
`ifdef LED_CHASER_BOUNCE_EN
                    bdir_q <= BDIR_UP;
`endif
                end
                ST_RUN: begin
                    if (mode_in != mode_q) begin
                        // Reload takes priority over a coinciding step
                        state <= ST_INIT;
                        tick  <= 1'b0;
                    end else if (wrap) begin
                        out  <= step_c;
                        tick <= 1'b1;
`ifdef LED_CHASER_BOUNCE_EN
                        bdir_q <= bdir_nxt_c;
`endif
                    end else begin
                        tick <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    tick  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: WIDTH=8/DIV=4 instance for the pattern
// sequences and WIDTH=2/DIV=1 instance for the every-cycle stepping case.
module tb_led_chaser;

    logic       clk = 1'b0;
    logic       res;
    logic [1:0] mode;
    logic       run;
    logic       dir;
    logic [7:0] out;
    logic       tick;

    logic       res_b;
    logic [1:0] out_b;
    logic       tick_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] cur;

    always #5 clk = ~clk;

    led_chaser #(.WIDTH(8), .DIV(4)) dut (
        .clk  (clk),
        .res  (res),
        .mode (mode),
        .run  (run),
        .dir  (dir),
        .out  (out),
        .tick (tick)
    );

    led_chaser #(.WIDTH(2), .DIV(1)) dut_b (
        .clk  (clk),
        .res  (res_b),
        .mode (2'd0),
        .run  (1'b1),
        .dir  (1'b0),
        .out  (out_b),
        .tick (tick_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Three idle prescaler cycles, then one step to value e with tick
    task automatic wait_step(input string tag, input logic [7:0] e);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk({tag, "_hold_out"}, 32'(out), 32'(cur));
            chk({tag, "_hold_tick"}, 32'(tick), 32'd0);
        end
        cyc();
        chk({tag, "_out"}, 32'(out), 32'(e));
        chk({tag, "_tick"}, 32'(tick), 32'd1);
        cur = e;
    endtask

    // Mode change: one cycle with no step, then INIT loads start pattern e
    task automatic reload(input string tag, input logic [1:0] m, input logic [7:0] e);
        mode = m;
        cyc();
        chk({tag, "_chg_out"}, 32'(out), 32'(cur));
        chk({tag, "_chg_tick"}, 32'(tick), 32'd0);
        cyc();
        chk({tag, "_init_out"}, 32'(out), 32'(e));
        chk({tag, "_init_tick"}, 32'(tick), 32'd0);
        cur = e;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        res   = 1'b1;
        res_b = 1'b1;
        mode  = 2'd0;
        run   = 1'b1;
        dir   = 1'b0;

        // Reset state and INIT for SHIFT
        cyc();
        chk("rst_out", 32'(out), 32'hFF);
        chk("rst_tick", 32'(tick), 32'd0);
        res = 1'b0;
        cyc();
        chk("init_shift_out", 32'(out), 32'h01);
        chk("init_shift_tick", 32'(tick), 32'd0);
        cur = 8'h01;

        // SHIFT toward MSB with wrap to bit0
        wait_step("shift1", 8'h02);
        wait_step("shift2", 8'h04);
        wait_step("shift3", 8'h08);
        wait_step("shift4", 8'h10);
        wait_step("shift5", 8'h20);
        wait_step("shift6", 8'h40);
        wait_step("shift7", 8'h80);
        wait_step("shift8", 8'h01);

        // FILL upward, then downward from 07, through all ones to zero
        reload("fill", 2'd1, 8'h00);
        wait_step("fill1", 8'h01);
        wait_step("fill2", 8'h03);
        wait_step("fill3", 8'h07);
        dir = 1'b1;
        wait_step("fill_d1", 8'h83);
        wait_step("fill_d2", 8'hC1);
        wait_step("fill_d3", 8'hE0);
        wait_step("fill_d4", 8'hF0);
        wait_step("fill_d5", 8'hF8);
        wait_step("fill_d6", 8'hFC);
        wait_step("fill_d7", 8'hFE);
        wait_step("fill_d8", 8'hFF);
        wait_step("fill_d9", 8'h00);
        dir = 1'b0;

        // ALT with a freeze partway through the prescaler count
        reload("alt", 2'd2, 8'h55);
        wait_step("alt1", 8'hAA);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("alt_pre_out", 32'(out), 32'hAA);
        end
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("frz_out", 32'(out), 32'hAA);
            chk("frz_tick", 32'(tick), 32'd0);
        end
        run = 1'b1;
        cyc();
        chk("resume_hold_out", 32'(out), 32'hAA);
        chk("resume_hold_tick", 32'(tick), 32'd0);
        cyc();
        chk("resume_out", 32'(out), 32'h55);
        chk("resume_tick", 32'(tick), 32'd1);
        cur = 8'h55;

        // Mode 3: BOUNCE when built in, otherwise SHIFT
        reload("bnc", 2'd3, 8'h01);
        wait_step("bnc_u1", 8'h02);
        wait_step("bnc_u2", 8'h04);
        wait_step("bnc_u3", 8'h08);
        wait_step("bnc_u4", 8'h10);
        wait_step("bnc_u5", 8'h20);
        wait_step("bnc_u6", 8'h40);
        wait_step("bnc_u7", 8'h80);
`ifdef LED_CHASER_BOUNCE_EN
        wait_step("bnc_d1", 8'h40);
        wait_step("bnc_d2", 8'h20);
        wait_step("bnc_d3", 8'h10);
        wait_step("bnc_d4", 8'h08);
        wait_step("bnc_d5", 8'h04);
        wait_step("bnc_d6", 8'h02);
        wait_step("bnc_d7", 8'h01);
        wait_step("bnc_u8", 8'h02);
`else
        wait_step("bnc_wrap", 8'h01);
`endif

        // Mode change landing exactly on the prescaler wrap
        reload("sh2", 2'd0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("prewrap_out", 32'(out), 32'h01);
        end
        reload("wrapchg", 2'd2, 8'h55);

        // Reset in the middle of a step interval
        reload("sh3", 2'd0, 8'h01);
        wait_step("sh3_1", 8'h02);
        wait_step("sh3_2", 8'h04);
        wait_step("sh3_3", 8'h08);
        wait_step("sh3_4", 8'h10);
        cyc();
        chk("midrst_pre_out", 32'(out), 32'h10);
        res = 1'b1;
        cyc();
        chk("midrst_out", 32'(out), 32'hFF);
        chk("midrst_tick", 32'(tick), 32'd0);
        res = 1'b0;
        cyc();
        chk("midrst_init_out", 32'(out), 32'h01);
        chk("midrst_init_tick", 32'(tick), 32'd0);

        // DIV=1, WIDTH=2: a step on every cycle, tick held high
        chk("b_rst_out", 32'(out_b), 32'h3);
        res_b = 1'b0;
        cyc();
        chk("b_init_out", 32'(out_b), 32'h1);
        chk("b_init_tick", 32'(tick_b), 32'd0);
        cyc();
        chk("b_s1_out", 32'(out_b), 32'h2);
        chk("b_s1_tick", 32'(tick_b), 32'd1);
        cyc();
        chk("b_s2_out", 32'(out_b), 32'h1);
        chk("b_s2_tick", 32'(tick_b), 32'd1);
        cyc();
        chk("b_s3_out", 32'(out_b), 32'h2);
        chk("b_s3_tick", 32'(tick_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter WIDTH, default 8, LED count; legal range 2..32.
REQ-002 Parameter DIV, default 2500000, clk cycles per pattern step; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 mode  input  2  pattern select: 0 SHIFT, 1 FILL, 2 ALT, 3 BOUNCE.
REQ-006 run  input  1  1 = advance on prescaler wrap; 0 = freeze.
REQ-007 dir  input  1  0 = toward MSB, 1 = toward LSB; ignored in ALT and BOUNCE.
REQ-008 out  output  WIDTH  registered LED pattern.
REQ-009 tick  output  1  registered one-cycle pulse, high in the cycle `out` takes a stepped value.

Function
REQ-010 FSM states: INIT and RUN; reset enters INIT.
REQ-011 INIT shall last exactly one cycle: `out` <= start pattern of the sampled `mode`, prescaler <= 0, FSM -> RUN, `tick` = 0.
REQ-012 Start patterns: SHIFT = bit0 set (dir=0) or bit WIDTH-1 set (dir=1); FILL = all zeros; ALT = 0101...01 (bit0 = 1); BOUNCE = bit0 set, internal bounce direction up.
REQ-013 Prescaler counts 0..DIV-1 while run=1; it holds its value and `out` holds while run=0.
REQ-014 On the cycle the prescaler equals DIV-1 with run=1: prescaler -> 0, `out` steps, `tick` = 1 in the next cycle. In all other cycles `tick` = 0.
REQ-015 DIV=1: `out` steps every cycle while run=1; `tick` stays high continuously.
REQ-016 SHIFT step: rotate by one position in `dir`; MSB wraps to bit0 (dir=0); bit0 wraps to MSB (dir=1).
REQ-017 FILL step: dir=0 -> (out<<1)|1; dir=1 -> (out>>1)|MSB; an all-ones value steps to all zeros.
REQ-018 ALT step: out <= ~out.
REQ-019 BOUNCE step: the one-hot bit moves one position in the bounce direction. On reaching MSB, the direction flips down. On reaching bit0, the direction flips up. The end bit is shown for exactly one step.
REQ-020 Mode change: when registered mode differs from `mode` in RUN, FSM -> INIT next cycle regardless of run. This also applies to a change coinciding with a prescaler wrap, where the reload wins over the step.
REQ-021 A change of `dir` in RUN takes effect at the next step with no reload.
REQ-022 Arithmetic is WIDTH bits, with no carry beyond the MSB. The prescaler is clog2(DIV) bits, minimum 1.

Reset
REQ-023 res=1 at posedge clk: `out` = all ones, `tick` = 0, prescaler = 0, bounce direction up, FSM = INIT. This holds in any state, mid-step included.
REQ-024 The first cycle after res falls executes INIT (REQ-011).

Configuration
REQ-025 Macro LED_CHASER_BOUNCE_EN defined: mode 3 = BOUNCE per REQ-019, with the bounce-direction register present.
REQ-026 Macro not defined: the bounce register and logic are absent, and mode 3 behaves exactly as SHIFT, including its start pattern.

Structure
REQ-027 Shared package led_pkg holds the mode encodings (MODE_SHIFT, MODE_FILL, MODE_ALT, MODE_BOUNCE) and the FSM state constants.
REQ-028 One sub-module, led_tick_div: inputs clk, res, run, clear (driven high in INIT); output wrap = 1 cycle at count DIV-1 with run=1; parameter DIV.
REQ-029 Pattern next-state logic stays in led_chaser.

Verification (WIDTH=8, DIV=4 unless stated)
REQ-030 Reset, then mode=0, dir=0, run=1: cycle 1 `out`=FF; INIT then `out`=01; `tick` every 4th cycle; `out` 02,04,...,80,01.
REQ-031 mode=1, dir=0: 00,01,03,07,...,FF,00. Switch to dir=1 mid-sequence at 07: next step 83.
REQ-032 mode=2: 55,AA,55. run=0 for 10 cycles: `out` and prescaler frozen, `tick`=0. Resume: first step after the remaining prescaler count.
REQ-033 With macro: mode=3 sequence 01,02,...,80,40,...,01,02. Without macro: mode=3 gives 01,...,80,01.
REQ-034 mode change 0->2 on the exact prescaler-wrap cycle: no step, INIT, `out`=55, `tick`=0. Assert res while `out`=10: next cycle FF.
REQ-035 DIV=1, WIDTH=2, mode=0: `out` 01,10,01 on consecutive cycles; `tick` constantly 1.
